// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a field that must hold values 0..pat_w inclusive.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Serial data, configuration and status bundle for seq_detector.
interface seq_detector_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LW = len_w(PAT_W);

  logic             x;
  logic             x_vld;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pat;
  logic [LW-1:0]    cfg_len;
  logic             cfg_overlap;
  logic             cfg_stop;
  logic             clr;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;

  modport master (
    output x, x_vld, cfg_load, cfg_pat, cfg_len, cfg_overlap, cfg_stop, clr,
    input  out, match_cnt, busy, done
  );

  modport slave (
    input  x, x_vld, cfg_load, cfg_pat, cfg_len, cfg_overlap, cfg_stop, clr,
    output out, match_cnt, busy, done
  );

endinterface

// File: rtl/seq_shreg.sv
// History shift register with a fill counter saturating at the active length.
module seq_shreg
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LW    = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic             drop,
  input  logic             x,
  input  logic [LW-1:0]    len,
  output logic [PAT_W-1:0] hist_sh,
  output logic [LW-1:0]    fill_sh
);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LW-1:0]    fill_q, fill_d;

  // hist_sh/fill_sh are the post-shift view the comparator judges; drop only
  // affects what gets stored, so there is no loop through the match logic.
  always_comb begin
    hist_sh = {hist_q[PAT_W-2:0], x};
    fill_sh = (fill_q >= len) ? len : fill_q + LW'(1);
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_sh;
      fill_d = drop ? '0 : fill_sh;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Configurable serial pattern detector: FSM, comparator, match counter and
// registered status outputs around a seq_shreg history register.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rstn,
  seq_detector_if.slave bus
);

  localparam int LW = len_w(PAT_W);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic             ovl_q, ovl_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sh_clr, sh_en, sh_drop;
  logic [PAT_W-1:0] hist_sh;
  logic [LW-1:0]    fill_sh;
  logic [PAT_W-1:0] mask;
  logic             match;
  logic [LW-1:0]    len_in;

  seq_shreg #(.PAT_W(PAT_W), .LW(LW)) u_shreg (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (sh_clr),
    .en      (sh_en),
    .drop    (sh_drop),
    .x       (bus.x),
    .len     (len_q),
    .hist_sh (hist_sh),
    .fill_sh (fill_sh)
  );

  always_comb begin
    for (int i = 0; i < PAT_W; i++) mask[i] = (LW'(i) < len_q);
    match = (fill_sh == len_q) && (((hist_sh ^ pat_q) & mask) == '0);
  end

  always_comb begin
    len_in = bus.cfg_len;
    if (len_in == '0)               len_in = LW'(1);
    else if (len_in > LW'(PAT_W))   len_in = LW'(PAT_W);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    stop_d  = stop_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    sh_clr  = 1'b0;
    sh_en   = 1'b0;
    sh_drop = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      sh_clr  = 1'b1;
      cnt_d   = '0;
    end else if (bus.cfg_load) begin
      state_d = RUN;
      pat_d   = bus.cfg_pat;
      len_d   = len_in;
      ovl_d   = bus.cfg_overlap;
      stop_d  = bus.cfg_stop;
      sh_clr  = 1'b1;
      cnt_d   = '0;
    end else if (state_q == RUN && bus.x_vld) begin
      sh_en = 1'b1;
      if (match) begin
        out_d   = 1'b1;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        sh_drop = !ovl_q;
        if (stop_q) state_d = DONE;
      end
    end
    // Status flags registered from the next state so they line up with state_q.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= LW'(1);
      ovl_q   <= 1'b0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.match_cnt = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits (legal 2..32).
REQ-002 Parameter CNT_W, default 8, match-counter width in bits.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 x  input  1  serial data bit.
REQ-006 x_vld  input  1  x is sampled only when x_vld=1.
REQ-007 cfg_load  input  1  single-cycle strobe that latches cfg_pat, cfg_len, cfg_overlap and cfg_stop.
REQ-008 cfg_pat  input  PAT_W  pattern; the bit received first compares against cfg_pat[len-1], the bit received last against cfg_pat[0].
REQ-009 cfg_len  input  $clog2(PAT_W+1)  active pattern length.
REQ-010 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 cfg_stop  input  1  1 = halt after the first match.
REQ-012 clr  input  1  single-cycle strobe: return to IDLE and clear the history and the counter.
REQ-013 out  output  1  registered match pulse.
REQ-014 match_cnt  output  CNT_W  number of matches since the last clear or load.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  high in DONE.

Function
REQ-017 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-018 State transitions SHALL be:
- IDLE to RUN on cfg_load.
- RUN to DONE on a match when cfg_stop=1.
- RUN or DONE back to RUN on cfg_load.
- Any state to IDLE on clr.
REQ-019 When clr and cfg_load are high in the same cycle, clr SHALL win.
REQ-020 Config clamping SHALL apply when cfg_load latches a value:
- cfg_len=0 is treated as 1.
- cfg_len>PAT_W is treated as PAT_W.
REQ-021 cfg_load SHALL clear the history register, the fill count and match_cnt.
REQ-022 In RUN with x_vld=1, x SHALL shift into bit 0 of a PAT_W-bit history register, and the fill count SHALL increment, saturating at len.
REQ-023 A match SHALL occur when, after the shift, fill count = len and history[len-1:0] = pat[len-1:0].
REQ-024 Match response:
- out=1 for exactly one cycle, in the cycle after the edge that sampled the completing bit.
- out=0 otherwise, including whenever x_vld=0.
REQ-025 After a match in overlap mode, the history and fill count SHALL be kept, so the next match can come as soon as the next bit.
REQ-026 After a match in non-overlap mode, the fill count SHALL reset to 0 so that the next match needs len fresh bits.
REQ-027 match_cnt SHALL increment on each match and saturate at 2^CNT_W-1 without wrapping.
REQ-028 In IDLE and DONE, x and x_vld SHALL be ignored; the history, fill count and match_cnt SHALL hold.
REQ-029 Configuration changes SHALL take effect only through cfg_load; cfg_* inputs are don't-care at all other times.

Reset
REQ-030 While rstn=0, the block SHALL asynchronously force:
- state = IDLE.
- out=0, busy=0, done=0, match_cnt=0.
- history=0, fill count=0.
- latched configuration = {pat=0, len=1, overlap=0, stop=0}.
REQ-031 Reset asserted mid-operation SHALL abort any partial match; no out pulse SHALL follow deassertion.
REQ-032 After rstn deasserts, the block SHALL stay in IDLE until a cfg_load arrives.

Structure
REQ-033 Package seq_det_pkg SHALL hold:
- the state enum {IDLE, RUN, DONE}.
- the function that derives the length-field width from PAT_W.
REQ-034 The history register with its fill counter SHALL be a single sub-module, seq_shreg, parametrised by PAT_W.
REQ-035 The top level SHALL contain the FSM, the comparator, the counter and the output registers.

Verification
REQ-036 Overlap: PAT_W=8, load pat=4'b1011, len=4, overlap=1; send 1,0,1,1,0,1,1 -> out pulses after the 4th and 7th bits; match_cnt=2.
REQ-037 Non-overlap: same stimulus with overlap=0 -> out pulses only after the 4th bit; match_cnt=1.
REQ-038 Gaps and stop: send the 4-bit pattern with x_vld=0 for 3 cycles between bits 2 and 3, cfg_stop=1 -> one pulse, done=1, busy=0; a further 1011 gives no pulse and match_cnt stays 1.
REQ-039 Saturation: CNT_W=2, len=1, pat=1, overlap=1; send 5 ones -> 5 pulses; match_cnt reaches 3 and holds.
REQ-040 Reset mid-match: send 1,0,1, then pulse rstn low, then send 1 -> no pulse; state=IDLE; all outputs 0.
REQ-041 Priority: assert clr and cfg_load together in RUN -> next state IDLE; match_cnt=0.
